// File: rtl/dmem_bram_ctrl_if.sv
// Core-side load/store request/response bundle.
// master = CPU data port, slave = BRAM controller.
interface dmem_bram_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_bram_ctrl.sv
// Data-side load/store controller driving port B of a 32-bit BRAM.
// One request in flight; load result held until the core accepts it.
module dmem_bram_ctrl #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmem_bram_ctrl_if.slave       bus,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [31:0]           bram_wr_data,
  output logic                  bram_wr_en,
  output logic [3:0]            bram_wr_byte_en,
  input  logic [31:0]           bram_rd_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] LAST_WAIT = 2'(RD_LATENCY - 1);

  logic [1:0]            r_state;
  logic [1:0]            r_cnt;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [1:0]            r_off;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_baddr;

  logic        w_accept;
  logic        w_range_err;
  logic        w_err;
  logic [31:0] w_lane;
  logic [31:0] w_load;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  assign w_accept = bus.req_valid & (r_state == IDLE);

  assign w_range_err =
    bus.req_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2];

  assign w_err = (bus.req_size == 2'd3)
    | ((bus.req_size == 2'd1) & bus.req_addr[0])
    | ((bus.req_size == 2'd2) & (|bus.req_addr[1:0]))
    | w_range_err;

  assign w_lane = bram_rd_data >> {r_off, 3'b000};

  always_comb begin
    w_load = w_lane;
    unique case (1'b1)
      (r_size == 2'd0):
        w_load = {{24{~r_uns & w_lane[7]}}, w_lane[7:0]};
      (r_size == 2'd1):
        w_load = {{16{~r_uns & w_lane[15]}}, w_lane[15:0]};
      default: w_load = w_lane;
    endcase
  end

  always_comb begin
    w_be    = 4'h0;
    w_wdata = r_wdata;
    unique case (1'b1)
      (r_size == 2'd0): begin
        w_be    = 4'b0001 << r_off;
        w_wdata = {4{r_wdata[7:0]}};
      end
      (r_size == 2'd1): begin
        w_be    = 4'b0011 << r_off;
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: w_be = 4'hF;
    endcase
    if (!((r_state == ISSUE) & r_we))
      w_be = 4'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_we    <= 1'b0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_off   <= 2'd0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
      r_baddr <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) begin
          r_we    <= bus.req_we;
          r_size  <= bus.req_size;
          r_uns   <= bus.req_unsigned;
          r_off   <= bus.req_addr[1:0];
          r_wdata <= bus.req_wdata;
          r_rdata <= 32'h0;
          r_err   <= w_err;
          if (w_err) begin
            r_state <= RESP;
          end else begin
            r_baddr <= bus.req_addr[ADDR_WIDTH+1:2];
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= 2'd0;
          r_state <= r_we ? RESP : WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt + 2'd1;
          // rd_data is valid in the final wait cycle only
          if (r_cnt == LAST_WAIT) begin
            r_rdata <= w_load;
            r_state <= RESP;
          end
        end
        RESP: if (bus.rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

  assign bram_addr       = r_baddr;
  assign bram_wr_en      = (r_state == ISSUE) & r_we;
  assign bram_wr_byte_en = w_be;
  assign bram_wr_data    = w_wdata;

endmodule
